// File: rtl/bp_uce_mem_responder_pkg.sv
// Purpose: shared types for the cache-engine memory message interface and the responder FSM.
// Contents: message/size enums, header and message structs, state enum, size-to-byte-mask helper.
// Latency/backpressure: n/a (types only).
package bp_uce_mem_responder_pkg;

  localparam int paddr_width_p         = 40;
  localparam int lce_id_width_p        = 4;
  localparam int way_id_width_p        = 2;
  localparam int cce_block_width_p     = 512;
  localparam int block_bytes_lp        = cce_block_width_p / 8;
  localparam int block_offset_width_lp = 6;

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'b0000,
    e_cce_mem_wr    = 4'b0001,
    e_cce_mem_uc_rd = 4'b0010,
    e_cce_mem_uc_wr = 4'b0011,
    e_cce_mem_wb    = 4'b0100
  } bp_cce_mem_cmd_type_e;

  typedef enum logic [2:0] {
    e_mem_size_1  = 3'd0,
    e_mem_size_2  = 3'd1,
    e_mem_size_4  = 3'd2,
    e_mem_size_8  = 3'd3,
    e_mem_size_16 = 3'd4,
    e_mem_size_32 = 3'd5,
    e_mem_size_64 = 3'd6
  } bp_mem_msg_size_e;

  typedef struct packed {
    logic [lce_id_width_p-1:0] lce_id;
    logic [way_id_width_p-1:0] way_id;
  } bp_cce_mem_payload_s;

  typedef struct packed {
    bp_cce_mem_cmd_type_e      msg_type;
    logic [paddr_width_p-1:0]  addr;
    bp_mem_msg_size_e          size;
    bp_cce_mem_payload_s       payload;
  } bp_cce_mem_hdr_s;

  typedef struct packed {
    bp_cce_mem_hdr_s               header;
    logic [cce_block_width_p-1:0]  data;
  } bp_cce_mem_msg_s;

  localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

  typedef enum logic [2:0] {
    e_reset = 3'd0,
    e_ready = 3'd1,
    e_latch = 3'd2,
    e_delay = 3'd3,
    e_resp  = 3'd4
  } bp_uce_mem_state_e;

  // Low 2^size bits set: the byte lanes an access of this size touches at offset 0.
  function automatic logic [block_bytes_lp-1:0] size_to_byte_mask(input bp_mem_msg_size_e size);
    case (size)
      e_mem_size_1:  return 64'h0000_0000_0000_0001;
      e_mem_size_2:  return 64'h0000_0000_0000_0003;
      e_mem_size_4:  return 64'h0000_0000_0000_000F;
      e_mem_size_8:  return 64'h0000_0000_0000_00FF;
      e_mem_size_16: return 64'h0000_0000_0000_FFFF;
      e_mem_size_32: return 64'h0000_0000_FFFF_FFFF;
      default:       return '1;
    endcase
  endfunction

endpackage

// File: rtl/bp_uce_mem_responder_mem.sv
// Purpose: single-port synchronous line store with per-byte write enables; contents never cleared.
// Ports: clk_i; v_i/w_i access strobe and write select; addr_i line index; data_i/write_mask_i; data_o.
// Latency: read data valid the cycle after a read access; holds until the next read.
module bp_uce_mem_responder_mem #(
  parameter int width_p = 512,
  parameter int els_p   = 1024,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [width_p/8-1:0]     write_mask_i,
  output logic [width_p-1:0]       data_o
);

  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge clk_i) begin
    if (v_i & w_i) begin
      for (int i = 0; i < width_p/8; i++) begin
        if (write_mask_i[i]) begin
          mem[addr_i][8*i +: 8] <= data_i[8*i +: 8];
        end
      end
    end
    if (v_i & ~w_i) begin
      data_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/bp_uce_mem_responder.sv
// Purpose: memory endpoint; one command at a time serviced from an internal line store, one response each.
// Ports: clk_i/reset_i (sync, active-high); mem_cmd_* valid/ready command in; mem_resp_* valid/yumi response out.
// Latency: accept at t -> response valid at t+2+mem_delay_p; response held indefinitely until yumi.
module bp_uce_mem_responder
  import bp_uce_mem_responder_pkg::*;
#(
  parameter int uce_assoc_p = 4,
  parameter int mem_els_p   = 1024,
  parameter int mem_delay_p = 0
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
  input  logic                            mem_cmd_v_i,
  output logic                            mem_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
  output logic                            mem_resp_v_o,
  input  logic                            mem_resp_yumi_i
);

  localparam int lg_els_lp = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;

  if (uce_assoc_p > (1 << way_id_width_p)) begin : g_bad_assoc
    $error("uce_assoc_p does not fit in payload.way_id");
  end
  if ((mem_delay_p < 0) || (mem_delay_p > 255)) begin : g_bad_delay
    $error("mem_delay_p must be 0..255");
  end

  // Expand a byte mask to a bit mask.
  function automatic logic [cce_block_width_p-1:0] bytes_to_bits(input logic [block_bytes_lp-1:0] m);
    logic [cce_block_width_p-1:0] b;
    for (int i = 0; i < block_bytes_lp; i++) b[8*i +: 8] = {8{m[i]}};
    return b;
  endfunction

  // Byte offset aligned down to the access size.
  function automatic logic [block_offset_width_lp-1:0] aligned_offset(input bp_cce_mem_hdr_s h);
    logic [6:0] n;
    n = 7'd1 << h.size;
    return h.addr[block_offset_width_lp-1:0] & ~6'(n - 7'd1);
  endfunction

  bp_uce_mem_state_e state_r, state_n;
  bp_cce_mem_msg_s   cmd;
  bp_cce_mem_msg_s   resp;
  bp_cce_mem_hdr_s   hdr_r;
  logic [cce_block_width_p-1:0] resp_data_r, latch_data;
  logic [7:0]        delay_cnt_r;
  logic              accept;

  logic                         mem_v, mem_w;
  logic [lg_els_lp-1:0]         mem_addr;
  logic [cce_block_width_p-1:0] mem_wdata, mem_rdata;
  logic [block_bytes_lp-1:0]    mem_mask;
  logic [block_offset_width_lp-1:0] cmd_off, hdr_off;

  assign cmd      = bp_cce_mem_msg_s'(mem_cmd_i);
  assign accept   = mem_cmd_ready_o & mem_cmd_v_i & ~reset_i;
  assign mem_addr = cmd.header.addr[block_offset_width_lp +: lg_els_lp];
  assign cmd_off  = aligned_offset(cmd.header);
  assign hdr_off  = aligned_offset(hdr_r);

  // Store access is issued in the accepting cycle, so writes land before any later command.
  always_comb begin
    mem_v     = 1'b0;
    mem_w     = 1'b0;
    mem_mask  = '0;
    mem_wdata = '0;
    if (accept) begin
      case (cmd.header.msg_type)
        e_cce_mem_rd, e_cce_mem_uc_rd: mem_v = 1'b1;
        e_cce_mem_wr, e_cce_mem_wb: begin
          mem_v     = 1'b1;
          mem_w     = 1'b1;
          mem_mask  = '1;
          mem_wdata = cmd.data;
        end
        e_cce_mem_uc_wr: begin
          mem_v     = 1'b1;
          mem_w     = 1'b1;
          mem_mask  = size_to_byte_mask(cmd.header.size) << cmd_off;
          mem_wdata = (cmd.data & bytes_to_bits(size_to_byte_mask(cmd.header.size)))
                      << {cmd_off, 3'b000};
        end
        default: ;
      endcase
    end
  end

  bp_uce_mem_responder_mem #(
    .width_p (cce_block_width_p),
    .els_p   (mem_els_p)
  ) line_store (
    .clk_i        (clk_i),
    .v_i          (mem_v),
    .w_i          (mem_w),
    .addr_i       (mem_addr),
    .data_i       (mem_wdata),
    .write_mask_i (mem_mask),
    .data_o       (mem_rdata)
  );

  // Shape store output into response data; non-read types return zero.
  always_comb begin
    latch_data = '0;
    case (hdr_r.msg_type)
      e_cce_mem_rd:    latch_data = mem_rdata;
      e_cce_mem_uc_rd: latch_data = (mem_rdata >> {hdr_off, 3'b000})
                                    & bytes_to_bits(size_to_byte_mask(hdr_r.size));
      default:         latch_data = '0;
    endcase
  end

  always_comb begin
    state_n         = state_r;
    mem_cmd_ready_o = 1'b0;
    mem_resp_v_o    = 1'b0;
    case (state_r)
      e_reset: state_n = e_ready;
      e_ready: begin
        mem_cmd_ready_o = 1'b1;
        if (mem_cmd_v_i) state_n = e_latch;
      end
      e_latch: state_n = (mem_delay_p != 0) ? e_delay : e_resp;
      e_delay: if (delay_cnt_r == 8'd1) state_n = e_resp;
      e_resp: begin
        mem_resp_v_o = 1'b1;
        if (mem_resp_yumi_i) state_n = e_ready;
      end
      default: state_n = e_reset;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= e_reset;
      hdr_r       <= '0;
      resp_data_r <= '0;
      delay_cnt_r <= '0;
    end else begin
      state_r <= state_n;
      if (accept) hdr_r <= cmd.header;
      if (state_r == e_latch) begin
        resp_data_r <= latch_data;
        delay_cnt_r <= 8'(mem_delay_p);
      end else if (state_r == e_delay) begin
        delay_cnt_r <= delay_cnt_r - 8'd1;
      end
    end
  end

  always_comb begin
    resp = '0;
    if (state_r == e_resp) begin
      resp.header = hdr_r;
      resp.data   = resp_data_r;
    end
  end
  assign mem_resp_o = resp;

endmodule

// File: tb/tb_bp_uce_mem_responder.sv
// Purpose: randomized and directed bench with a byte-array memory model and per-cycle output compare.
// Ports: none; drives a delay-3 responder with full checking and a delay-0 responder with directed checks.
// Latency/backpressure: model predicts response cycle and ready cycle; yumi held off randomly.
module tb_bp_uce_mem_responder;
  import bp_uce_mem_responder_pkg::*;

  localparam int DLY = 3;
  localparam int ELS = 1024;
  localparam int W   = cce_mem_msg_width_lp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_i = 1'b1;
  logic [W-1:0] mem_cmd_i = '0;
  logic         mem_cmd_v_i = 1'b0;
  logic         mem_cmd_ready_o;
  logic [W-1:0] mem_resp_o;
  logic         mem_resp_v_o;
  logic         mem_resp_yumi_i = 1'b0;

  logic         d0_reset = 1'b1;
  logic [W-1:0] d0_cmd = '0;
  logic         d0_v = 1'b0;
  logic         d0_ready;
  logic [W-1:0] d0_resp;
  logic         d0_resp_v;
  logic         d0_yumi = 1'b0;

  bp_uce_mem_responder #(.uce_assoc_p(4), .mem_els_p(ELS), .mem_delay_p(DLY)) dut (
    .clk_i(clk), .reset_i(reset_i), .mem_cmd_i(mem_cmd_i), .mem_cmd_v_i(mem_cmd_v_i),
    .mem_cmd_ready_o(mem_cmd_ready_o), .mem_resp_o(mem_resp_o), .mem_resp_v_o(mem_resp_v_o),
    .mem_resp_yumi_i(mem_resp_yumi_i));

  bp_uce_mem_responder #(.uce_assoc_p(4), .mem_els_p(ELS), .mem_delay_p(0)) dut_d0 (
    .clk_i(clk), .reset_i(d0_reset), .mem_cmd_i(d0_cmd), .mem_cmd_v_i(d0_v),
    .mem_cmd_ready_o(d0_ready), .mem_resp_o(d0_resp), .mem_resp_v_o(d0_resp_v),
    .mem_resp_yumi_i(d0_yumi));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mb [ELS*64];
  bit              pending   = 0;
  int              resp_cyc  = 0;
  int              ready_ok  = 5;
  int              rst_start = 0;
  int              rst_end   = 3;
  bp_cce_mem_msg_s exp_resp  = '0;

  function automatic int line_of(input bp_cce_mem_msg_s c);
    return int'(c.header.addr[6 +: 10]);
  endfunction

  function automatic bp_cce_mem_msg_s model_resp(input bp_cce_mem_msg_s c);
    bp_cce_mem_msg_s r;
    int l, off, n, base;
    r = '0;
    r.header = c.header;
    l = line_of(c);
    off = int'(c.header.addr[5:0]);
    n = 1 << int'(c.header.size);
    base = off - (off % n);
    if (c.header.msg_type == e_cce_mem_rd)
      for (int b = 0; b < 64; b++) r.data[8*b +: 8] = mb[l*64 + b];
    else if (c.header.msg_type == e_cce_mem_uc_rd)
      for (int b = 0; b < n; b++) r.data[8*b +: 8] = mb[l*64 + base + b];
    return r;
  endfunction

  task automatic model_apply(input bp_cce_mem_msg_s c);
    int l, off, n, base;
    l = line_of(c);
    off = int'(c.header.addr[5:0]);
    n = 1 << int'(c.header.size);
    base = off - (off % n);
    if (c.header.msg_type == e_cce_mem_wr || c.header.msg_type == e_cce_mem_wb)
      for (int b = 0; b < 64; b++) mb[l*64 + b] = c.data[8*b +: 8];
    else if (c.header.msg_type == e_cce_mem_uc_wr)
      for (int b = 0; b < n; b++) mb[l*64 + base + b] = c.data[8*b +: 8];
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit in_rst, exp_v, exp_r;
    if (cyc != rst_start) begin
      in_rst = (cyc > rst_start) && (cyc <= rst_end + 1);
      exp_v  = !in_rst && pending && (cyc >= resp_cyc);
      exp_r  = !in_rst && !pending && (cyc >= ready_ok);
      chk("resp_v", W'(mem_resp_v_o), W'(exp_v));
      chk("cmd_ready", W'(mem_cmd_ready_o), W'(exp_r));
      if (exp_v) chk("resp_msg", mem_resp_o, exp_resp);
      else if (in_rst) chk("resp_in_reset", mem_resp_o, '0);
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [511:0] rnd512();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  function automatic bp_cce_mem_msg_s mk(input logic [3:0] t, input logic [39:0] a, input int sz,
                                         input int lce, input int way, input logic [511:0] d);
    bp_cce_mem_msg_s m;
    m.header.msg_type       = bp_cce_mem_cmd_type_e'(t);
    m.header.addr           = a;
    m.header.size           = bp_mem_msg_size_e'(sz[2:0]);
    m.header.payload.lce_id = lce[3:0];
    m.header.payload.way_id = way[1:0];
    m.data                  = d;
    return m;
  endfunction

  task automatic scramble_cmd();
    logic [607:0] junk;
    for (int k = 0; k < 19; k++) junk[32*k +: 32] = $urandom;
    mem_cmd_i = junk[W-1:0];
  endtask

  task automatic txn(input bp_cce_mem_msg_s c, input int hold, output bp_cce_mem_msg_s got, output int lat);
    bit ok;
    int acc;
    got = '0;
    lat = -1;
    mem_cmd_i = c;
    mem_cmd_v_i = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_cmd_ready_o) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      mem_cmd_v_i = 1'b0;
      return;
    end
    #1;
    acc = cyc;
    exp_resp = model_resp(c);
    model_apply(c);
    pending = 1;
    resp_cyc = acc + 2 + DLY;
    @(posedge clk); #1;
    mem_cmd_v_i = 1'b0;
    scramble_cmd();
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mem_resp_v_o) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      chk("resp_timeout", 0, 1);
      pending = 0;
      return;
    end
    lat = cyc - acc;
    got = mem_resp_o;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
    end
    #1 mem_resp_yumi_i = 1'b1;
    @(posedge clk); #1;
    mem_resp_yumi_i = 1'b0;
    pending = 0;
    ready_ok = cyc;
  endtask

  task automatic d0_txn(input bp_cce_mem_msg_s c, output bp_cce_mem_msg_s got, output int lat);
    bit ok;
    int acc;
    got = '0;
    lat = -1;
    d0_cmd = c;
    d0_v = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d0_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      chk("d0_accept_timeout", 0, 1);
      d0_v = 1'b0;
      return;
    end
    acc = cyc;
    @(posedge clk); #1;
    d0_v = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d0_resp_v) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      chk("d0_resp_timeout", 0, 1);
      return;
    end
    lat = cyc - acc;
    got = d0_resp;
    #1 d0_yumi = 1'b1;
    @(posedge clk); #1;
    d0_yumi = 1'b0;
  endtask

  initial begin
    #(50000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bp_cce_mem_msg_s c, got;
    int lat;
    logic [511:0] ramp, pat;
    logic [63:0]  lo64;

    for (int i = 0; i < 64; i++) ramp[8*i +: 8] = 8'(i);

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("d0_reset_ready", W'(d0_ready), 0);
    chk("d0_reset_resp_v", W'(d0_resp_v), 0);
    chk("d0_reset_resp", d0_resp, '0);
    @(posedge clk); @(posedge clk); #1;
    reset_i = 1'b0;
    d0_reset = 1'b0;

    // Fill the random pool (lines 0..7) with known contents.
    for (int l = 0; l < 8; l++) begin
      c = mk(4'(e_cce_mem_wr), {24'h0, 10'(l), 6'h0}, 6, l, l, rnd512());
      txn(c, 0, got, lat);
    end

    // Full-line write then read with payload echo.
    c = mk(4'(e_cce_mem_wr), 40'h00_8000_0040, 6, 1, 2, ramp);
    txn(c, 0, got, lat);
    chk("wr_resp_data_zero", W'(got.data), 0);
    c = mk(4'(e_cce_mem_rd), 40'h00_8000_0040, 6, 1, 2, '0);
    txn(c, 0, got, lat);
    chk("rd_ramp", W'(got.data), W'(ramp));
    chk("rd_lce_id", W'(got.header.payload.lce_id), 1);
    chk("rd_way_id", W'(got.header.payload.way_id), 2);
    chk("rd_latency", W'(lat), W'(2 + 3));

    // Uncached 4B write at misaligned 0x45, then 8B uncached read.
    c = mk(4'(e_cce_mem_uc_wr), 40'h00_8000_0045, 2, 3, 1, 512'hDEADBEEF);
    txn(c, 0, got, lat);
    c = mk(4'(e_cce_mem_uc_rd), 40'h00_8000_0040, 3, 3, 1, rnd512());
    txn(c, 0, got, lat);
    lo64 = got.data[63:0];
    chk("uc_rd_low64", W'(lo64), W'(64'hDEADBEEF_03020100));
    chk("uc_rd_upper_zero", W'(got.data[511:64]), 0);

    // Long backpressure: response must hold, ready must stay low.
    c = mk(4'(e_cce_mem_rd), 40'h00_8000_0040, 6, 5, 3, '0);
    txn(c, 6, got, lat);

    // Aliasing across high address bits.
    pat = rnd512();
    c = mk(4'(e_cce_mem_wr), 40'h00_0000_0000, 6, 0, 0, pat);
    txn(c, 0, got, lat);
    c = mk(4'(e_cce_mem_rd), 40'h00_0001_0000, 6, 0, 0, '0);
    txn(c, 0, got, lat);
    chk("alias_rd", W'(got.data), W'(pat));

    // Reset while in the delay phase: no response, write retained.
    pat = rnd512();
    c = mk(4'(e_cce_mem_wr), {24'h0, 10'd5, 6'h0}, 6, 2, 2, pat);
    mem_cmd_i = c;
    mem_cmd_v_i = 1'b1;
    begin
      bit ok;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (mem_cmd_ready_o) begin ok = 1; break; end
        @(posedge clk); #1;
      end
      if (!ok) chk("rst_accept_timeout", 0, 1);
    end
    #1;
    exp_resp = model_resp(c);
    model_apply(c);
    pending = 1;
    resp_cyc = cyc + 2 + DLY;
    @(posedge clk); #1;
    mem_cmd_v_i = 1'b0;
    @(posedge clk); #1;
    reset_i = 1'b1;
    rst_start = cyc;
    rst_end = 1 << 30;
    pending = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    rst_end = cyc - 1;
    ready_ok = cyc + 1;
    repeat (10) @(posedge clk);
    #1;
    c = mk(4'(e_cce_mem_rd), {24'h0, 10'd5, 6'h0}, 6, 2, 2, '0);
    txn(c, 0, got, lat);
    chk("rst_write_retained", W'(got.data), W'(pat));

    // Randomized traffic over the pool, with aliasing high bits.
    for (int k = 0; k < 60; k++) begin
      int t, sz;
      logic [3:0] ty;
      t = int'($urandom_range(0, 5));
      case (t)
        0: ty = 4'(e_cce_mem_rd);
        1: ty = 4'(e_cce_mem_wr);
        2: ty = 4'(e_cce_mem_wb);
        3: ty = 4'(e_cce_mem_uc_rd);
        4: ty = 4'(e_cce_mem_uc_wr);
        default: ty = 4'hA;
      endcase
      sz = (t == 3 || t == 4) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 6));
      c = mk(ty, {24'($urandom), 10'($urandom_range(0, 7)), 6'($urandom)}, sz,
             int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), rnd512());
      txn(c, int'($urandom_range(0, 3)), got, lat);
    end

    // Zero-delay instance: latency and write/read round trip.
    pat = rnd512();
    c = mk(4'(e_cce_mem_wr), 40'h00_0000_00C0, 6, 4, 1, pat);
    d0_txn(c, got, lat);
    chk("d0_wr_latency", W'(lat), 2);
    c = mk(4'(e_cce_mem_rd), 40'h00_0000_00C0, 6, 4, 1, '0);
    d0_txn(c, got, lat);
    chk("d0_rd_latency", W'(lat), 2);
    chk("d0_rd_data", W'(got.data), W'(pat));
    chk("d0_rd_addr", W'(got.header.addr), W'(40'h00_0000_00C0));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
